mem_panel: RTL and testbench
============================

Name: mem_panel

Overview:
- Main memory that sits directly downstream of the CPU core. It consumes the core's address, write data, read and write strobes, and returns read data on the core's 8-bit data input.
- It also contains a front-panel loader. In load mode, an operator enters a program byte by byte from switches and a store button, with an auto-incrementing load address.
- The core and the panel never access memory at the same time: cpustate selects which one owns the memory.

Parameters:
- AW, 8, memory address width; DEPTH = 2**AW bytes.
- DB_CYCLES, 4, number of consecutive stable samples a panel button needs before it is accepted (minimum 1).

Ports:
- clk  input  1  the single memory/panel clock.
- rst  input  1  asynchronous, active-high reset.
- cpustate  input  2  mode select: 2'b01 = load, 2'b10 = run; 2'b00 and 2'b11 = hold.
- addr  input  16  core address; only addr[AW-1:0] is used, upper bits are ignored.
- wdata  input  8  core write data.
- read  input  1  core read strobe.
- write  input  1  core write strobe.
- rdata  output  8  read data returned to the core.
- sw_data  input  8  panel data switches.
- btn_store  input  1  raw panel button: write sw_data at load_addr, then increment load_addr.
- btn_aset  input  1  raw panel button: load_addr <= sw_data[AW-1:0].
- load_addr  output  AW  current panel load address.
- store_ack  output  1  one-cycle pulse when a panel store commits.
- busy  output  1  high while the loader FSM is not in L_IDLE.

Behaviour:
- Reset values:
  - rdata = 0, load_addr = 0, store_ack = 0, busy = 0.
  - FSM = L_IDLE; synchronisers, debounce counters and edge registers = 0.
  - RAM contents are not reset.
- Run mode (cpustate = 2'b10):
  - rdata = mem[addr[AW-1:0]] combinationally while read = 1, otherwise 8'h00. This is zero-latency, because the core samples its data input in the same cycle it asserts read.
  - write = 1: mem[addr] <= wdata at the rising clk edge.
  - read and write together: the write commits at the edge; rdata shows the pre-write content until that edge.
  - Panel buttons are ignored, but still synchronised and debounced.
- Hold and load modes: core read and write are ignored, and rdata = 0.
- Button path (per button):
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive equal samples.
  - A rising edge of the debounced level produces a one-cycle press event.
- Loader FSM (active only in load mode):
  - L_IDLE: on aset_press, go to L_ASET. Otherwise, on store_press, go to L_STORE.
  - L_ASET: load_addr <= sw_data[AW-1:0]; go to L_WAIT.
  - L_STORE: mem[load_addr] <= sw_data; store_ack = 1; go to L_INC.
  - L_INC: load_addr <= load_addr + 1, wrapping from DEPTH-1 to 0; go to L_WAIT.
  - L_WAIT: stay until both debounced levels are 0; then go to L_IDLE. One press therefore gives exactly one action.
- Simultaneous events:
  - aset_press and store_press in the same cycle: aset wins and the store is dropped.
  - A press arriving while the FSM is not in L_IDLE is dropped.
- Mode exit: if cpustate leaves load mode in any state, the FSM goes to L_IDLE on the next edge.
  - A write already committed in L_STORE stands.
  - An L_INC not yet executed is lost, so load_addr is not incremented.
  - load_addr is otherwise retained across mode changes.
- Reset mid-operation: all state returns to reset values immediately. A RAM write is not performed on an edge where rst = 1.
- Total latency from a raw button press to the commit: 2 (synchroniser) + DB_CYCLES + 1 (edge) + 1 (FSM) cycles.

Decomposition:
- Shared package:
  - Mode constants MODE_HOLD = 2'b00, MODE_LOAD = 2'b01, MODE_RUN = 2'b10.
  - Loader state encoding L_IDLE, L_ASET, L_STORE, L_INC, L_WAIT.
- One sub-module, btn_debounce (synchroniser + counter + rising-edge detect, parameter DB_CYCLES), instantiated twice.
- The RAM is an inferred array inside mem_panel with a single write port, muxed between core and loader by mode.

Test Plan:
- Reset, then load mode. Press aset with sw_data = 8'h10, then store 8'hA5 and store 8'h3C. Required: mem[0x10] = A5, mem[0x11] = 3C, load_addr = 0x12, two store_ack pulses.
- Load mode, aset with sw_data = 8'hFF (AW = 8), then store 8'h77. Required: mem[0xFF] = 77 and load_addr wraps to 0x00.
- Hold btn_store high for 50 cycles, plus a 2-cycle glitch shorter than DB_CYCLES. Required: exactly one store_ack, and the glitch produces no action.
- Run mode, addr = 16'hAB20 (upper bits ignored), write = 1, wdata = 8'h5E for one cycle, then read = 1. Required: rdata = 8'h5E in the same cycle as read, and 8'h00 when read = 0.
- aset and store pressed in the same cycle. Required: load_addr = sw_data and no memory write occurs.
- Assert rst while the FSM is in L_INC after a store to 0x20. Required: load_addr = 0, busy = 0, mem[0x20] keeps the stored value.

Source files
------------

// File: rtl/mem_panel_pkg.sv
// Shared constants for the memory/front-panel block: mode encodings and loader states.
package mem_panel_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;

    typedef enum logic [2:0] {
        L_IDLE  = 3'd0,
        L_ASET  = 3'd1,
        L_STORE = 3'd2,
        L_INC   = 3'd3,
        L_WAIT  = 3'd4
    } load_state_e;

endpackage

// File: rtl/mem_panel_btn_debounce.sv
// Panel button conditioning: 2-flop synchroniser, stable-sample debounce counter and
// rising-edge detect producing a single-cycle press event.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level flips only once DB_CYCLES consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/mem_panel.sv
// Main memory behind the CPU core with a front-panel byte loader; cpustate decides
// whether the core (run) or the panel loader (load) owns the single RAM write port.
module mem_panel
    import mem_panel_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cpustate,
    input  logic [15:0]   addr,
    input  logic [7:0]    wdata,
    input  logic          read,
    input  logic          write,
    output logic [7:0]    rdata,
    input  logic [7:0]    sw_data,
    input  logic          btn_store,
    input  logic          btn_aset,
    output logic [AW-1:0] load_addr,
    output logic          store_ack,
    output logic          busy
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    load_state_e   state_q, state_d;
    logic [AW-1:0] load_addr_q, load_addr_d;
    logic          live_q;
    logic          load_mode, run_mode;
    logic          aset_level, aset_press, store_level, store_press;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          unused_addr;

    assign load_mode   = (cpustate == MODE_LOAD);
    assign run_mode    = (cpustate == MODE_RUN);
    assign unused_addr = ^addr[15:AW];

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_aset (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn_aset),
        .level_o (aset_level),
        .press_o (aset_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_store (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn_store),
        .level_o (store_level),
        .press_o (store_press)
    );

    // Low while reset is held and for the first edge after release, so no RAM write
    // can land on an edge where rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= 1'b0;
            state_q     <= L_IDLE;
            load_addr_q <= '0;
        end else begin
            live_q      <= 1'b1;
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!load_mode) begin
            state_d = L_IDLE;
        end else begin
            unique case (state_q)
                L_IDLE: begin
                    if (aset_press) begin
                        state_d = L_ASET;
                    end else if (store_press) begin
                        state_d = L_STORE;
                    end
                end
                L_ASET:  state_d = L_WAIT;
                L_STORE: state_d = L_INC;
                L_INC:   state_d = L_WAIT;
                L_WAIT: begin
                    if (!aset_level && !store_level) begin
                        state_d = L_IDLE;
                    end
                end
                default: state_d = L_IDLE;
            endcase
        end
    end

    always_comb begin
        load_addr_d = load_addr_q;
        if (load_mode && state_q == L_ASET) begin
            load_addr_d = sw_data[AW-1:0];
        end else if (load_mode && state_q == L_INC) begin
            load_addr_d = load_addr_q + AW'(1);
        end
    end

    always_comb begin
        busy      = (state_q != L_IDLE);
        store_ack = load_mode && (state_q == L_STORE);
        load_addr = load_addr_q;
        rdata     = (live_q && run_mode && read) ? mem[addr[AW-1:0]] : 8'h00;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (run_mode && write) begin
            mem_we    = live_q;
            mem_waddr = addr[AW-1:0];
            mem_wdata = wdata;
        end else if (store_ack) begin
            mem_we    = live_q;
            mem_waddr = load_addr_q;
            mem_wdata = sw_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_panel.sv
// Randomised self-checking bench for mem_panel against a array-based memory/loader model.
module tb_mem_panel;
    import mem_panel_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cpustate = MODE_HOLD;
    logic [15:0]   addr = '0;
    logic [7:0]    wdata = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [7:0]    rdata;
    logic [7:0]    sw_data = '0;
    logic          btn_store = 1'b0;
    logic          btn_aset = 1'b0;
    logic [AW-1:0] load_addr;
    logic          store_ack;
    logic          busy;

    mem_panel #(.AW(AW), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpustate  (cpustate),
        .addr      (addr),
        .wdata     (wdata),
        .read      (read),
        .write     (write),
        .rdata     (rdata),
        .sw_data   (sw_data),
        .btn_store (btn_store),
        .btn_aset  (btn_aset),
        .load_addr (load_addr),
        .store_ack (store_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]    mem_m [256];
    logic [AW-1:0] la_m = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_write(input logic [7:0] hi, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpustate = MODE_RUN; read = 1'b0; addr = {hi, a}; wdata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic run_read(input string tag, input logic [7:0] a);
        @(posedge clk); #1;
        cpustate = MODE_RUN; write = 1'b0; addr = {8'($urandom), a}; read = 1'b1;
        #1 check(tag, 32'(rdata), 32'(mem_m[a]));
        read = 1'b0;
        #1 check({tag, "_noread"}, 32'(rdata), 32'h0);
    endtask

    task automatic press(input bit a_b, input bit s_b, input logic [7:0] d, input int hold,
                         input string tag);
        int acks = 0;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; cpustate = MODE_LOAD; sw_data = d;
        btn_aset = a_b; btn_store = s_b;
        repeat (hold) begin
            @(negedge clk);
            if (store_ack) acks++;
        end
        btn_aset = 1'b0; btn_store = 1'b0;
        repeat (DB + 8) begin
            @(negedge clk);
            if (store_ack) acks++;
        end
        if (a_b) begin
            la_m = d[AW-1:0];
        end else if (s_b) begin
            mem_m[la_m] = d;
            la_m = la_m + 1'b1;
        end
        check({tag, "_acks"}, 32'(acks), (!a_b && s_b) ? 32'd1 : 32'd0);
        check({tag, "_addr"}, 32'(load_addr), 32'(la_m));
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  acks;
        int  busy_seen;
        bit  seen;
        logic [7:0] d;
        logic [7:0] old_la;

        // Reset state, with a run-mode read already requested.
        cpustate = MODE_RUN; read = 1'b1;
        #2;
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_load_addr", 32'(load_addr), 32'h0);
        check("rst_store_ack", 32'(store_ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        read = 1'b0; cpustate = MODE_HOLD; rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 256; i++) run_write(8'($urandom), 8'(i), 8'($urandom));

        // Sequential load from 0x10.
        press(1'b1, 1'b0, 8'h10, 20, "ld_aset10");
        press(1'b0, 1'b1, 8'hA5, 20, "ld_storeA5");
        press(1'b0, 1'b1, 8'h3C, 20, "ld_store3C");
        check("ld_addr12", 32'(load_addr), 32'h12);
        run_read("ld_mem10", 8'h10);
        run_read("ld_mem11", 8'h11);

        // Address wrap at the top of memory.
        press(1'b1, 1'b0, 8'hFF, 20, "wrap_asetFF");
        press(1'b0, 1'b1, 8'h77, 20, "wrap_store77");
        check("wrap_addr0", 32'(load_addr), 32'h0);
        run_read("wrap_memFF", 8'hFF);

        // Long hold gives one store; short glitch gives none.
        press(1'b0, 1'b1, 8'($urandom), 50, "hold50");
        @(posedge clk); #1;
        cpustate = MODE_LOAD; btn_store = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_store = 1'b0;
        acks = 0; busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (store_ack) acks++;
            if (busy) busy_seen++;
        end
        check("glitch_acks", 32'(acks), 32'h0);
        check("glitch_busy", 32'(busy_seen), 32'h0);
        check("glitch_addr", 32'(load_addr), 32'(la_m));

        // Run-mode write/read with upper address bits set, plus read-during-write.
        run_write(8'hAB, 8'h20, 8'h5E);
        @(posedge clk); #1;
        addr = 16'hAB20; read = 1'b1;
        #1 check("run_rd_5E", 32'(rdata), 32'h5E);
        read = 1'b0;
        #1 check("run_rd_off", 32'(rdata), 32'h0);
        @(posedge clk); #1;
        addr = 16'h1220; read = 1'b1; write = 1'b1; wdata = 8'hC3;
        #1 check("rw_pre", 32'(rdata), 32'h5E);
        @(posedge clk); #1;
        write = 1'b0; mem_m[8'h20] = 8'hC3;
        #1 check("rw_post", 32'(rdata), 32'hC3);
        read = 1'b0;

        // Simultaneous aset and store: aset wins, no write.
        old_la = 8'(la_m);
        d = 8'h5A;
        press(1'b1, 1'b1, d, 20, "both");
        check("both_addr", 32'(load_addr), 32'h5A);
        run_read("both_mem_old", old_la);
        run_read("both_mem_new", d);

        // Reset while the loader sits in L_INC after a store to 0x20.
        press(1'b1, 1'b0, 8'h20, 20, "rst_aset20");
        @(posedge clk); #1;
        sw_data = 8'h96; btn_store = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (store_ack) seen = 1'b1;
        end
        check("rst_ack_seen", 32'(seen), 32'h1);
        @(posedge clk); #1;
        check("rst_inc_busy", 32'(busy), 32'h1);
        rst = 1'b1; cpustate = MODE_HOLD;
        #1;
        check("rst_mid_addr", 32'(load_addr), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_ack", 32'(store_ack), 32'h0);
        btn_store = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mem_m[8'h20] = 8'h96; la_m = '0;
        repeat (DB + 4) @(negedge clk);
        run_read("rst_mem20", 8'h20);

        // Random mix of panel and core traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: press(1'b1, 1'b0, 8'($urandom), 20, "rnd_aset");
                1: press(1'b0, 1'b1, 8'($urandom), $urandom_range(DB + 6, 30), "rnd_store");
                2: run_write(8'($urandom), 8'($urandom), 8'($urandom));
                default: run_read("rnd_read", 8'($urandom));
            endcase
        end
        for (int i = 0; i < 8; i++) run_read("final_read", 8'(la_m - 8'(i)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
